// File: rtl/convertidor_binario_bcd_if.sv
// Start/done handshake bundle for the binary-to-BCD converter.
// The signo line exists only when CONVERTIDOR_SIGNO_EN is defined.
interface convertidor_binario_bcd_if #(
  parameter int unsigned ANCHO_BIN = 16,
  parameter int unsigned DIGITOS   = 5
);
  logic                   inicio;
  logic [ANCHO_BIN-1:0]   entrada_bin;
  logic [4*DIGITOS-1:0]   resultado_bcd;
  logic                   terminado;
`ifdef CONVERTIDOR_SIGNO_EN
  logic                   signo;

  modport master (
    output inicio, entrada_bin,
    input  resultado_bcd, terminado, signo
  );

  modport slave (
    input  inicio, entrada_bin,
    output resultado_bcd, terminado, signo
  );
`else
  modport master (
    output inicio, entrada_bin,
    input  resultado_bcd, terminado
  );

  modport slave (
    input  inicio, entrada_bin,
    output resultado_bcd, terminado
  );
`endif
endinterface

// File: rtl/convertidor_binario_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one digit adjust plus one shift per input bit.
// Define CONVERTIDOR_SIGNO_EN for two's-complement input with a signo output.
module convertidor_binario_bcd #(
  parameter int unsigned ANCHO_BIN = 16,
  parameter int unsigned DIGITOS   = 5
) (
  input logic                         reloj,
  input logic                         reset,
  convertidor_binario_bcd_if.slave    bus
);

  localparam int unsigned ANCHO_BCD  = 4 * DIGITOS;
  localparam int unsigned ANCHO_TRAB = ANCHO_BCD + ANCHO_BIN;
  localparam int unsigned ANCHO_CONT = $clog2(ANCHO_BIN + 1);

  typedef enum logic [1:0] {
    ESPERA,
    AJUSTE,
    DESPLAZA,
    FIN
  } estado_t;

  estado_t                estado, estado_sig;
  logic [ANCHO_TRAB-1:0]  trabajo, trabajo_sig;
  logic [ANCHO_TRAB-1:0]  ajustado;
  logic [ANCHO_CONT-1:0]  contador, contador_sig;
  logic [ANCHO_BCD-1:0]   resultado, resultado_sig;
  logic                   terminado, terminado_sig;
  logic [ANCHO_BIN-1:0]   magnitud;
`ifdef CONVERTIDOR_SIGNO_EN
  logic                   negativo, negativo_sig;
  logic                   signo, signo_sig;
`endif

  // Operand magnitude as loaded into the binary half of the work register.
  always_comb begin
`ifdef CONVERTIDOR_SIGNO_EN
    if (bus.entrada_bin[ANCHO_BIN-1]) begin
      magnitud = ~bus.entrada_bin + ANCHO_BIN'(1);
    end else begin
      magnitud = bus.entrada_bin;
    end
`else
    magnitud = bus.entrada_bin;
`endif
  end

  // Each BCD nibble >= 5 gets +3 so the following shift carries into the next decade.
  always_comb begin
    ajustado = trabajo;
    for (int unsigned i = 0; i < DIGITOS; i++) begin
      if (trabajo[ANCHO_BIN + 4*i +: 4] >= 4'd5) begin
        ajustado[ANCHO_BIN + 4*i +: 4] = trabajo[ANCHO_BIN + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    estado_sig    = estado;
    trabajo_sig   = trabajo;
    contador_sig  = contador;
    resultado_sig = resultado;
    terminado_sig = terminado;
`ifdef CONVERTIDOR_SIGNO_EN
    negativo_sig  = negativo;
    signo_sig     = signo;
`endif
    case (estado)
      ESPERA: begin
        if (bus.inicio) begin
          trabajo_sig   = {{ANCHO_BCD{1'b0}}, magnitud};
          contador_sig  = ANCHO_CONT'(ANCHO_BIN);
          terminado_sig = 1'b0;
`ifdef CONVERTIDOR_SIGNO_EN
          negativo_sig  = bus.entrada_bin[ANCHO_BIN-1];
`endif
          estado_sig    = AJUSTE;
        end
      end
      AJUSTE: begin
        trabajo_sig = ajustado;
        estado_sig  = DESPLAZA;
      end
      DESPLAZA: begin
        trabajo_sig  = {trabajo[ANCHO_TRAB-2:0], 1'b0};
        contador_sig = contador - ANCHO_CONT'(1);
        // Last shift: publish the BCD half as it will look after this shift.
        if (contador == ANCHO_CONT'(1)) begin
          resultado_sig = trabajo[ANCHO_TRAB-2 -: ANCHO_BCD];
          terminado_sig = 1'b1;
`ifdef CONVERTIDOR_SIGNO_EN
          signo_sig     = negativo;
`endif
          estado_sig    = FIN;
        end else begin
          estado_sig    = AJUSTE;
        end
      end
      FIN: begin
        if (!bus.inicio) begin
          estado_sig = ESPERA;
        end
      end
      default: begin
        estado_sig = ESPERA;
      end
    endcase
  end

  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      estado    <= ESPERA;
      trabajo   <= '0;
      contador  <= '0;
      resultado <= '0;
      terminado <= 1'b0;
`ifdef CONVERTIDOR_SIGNO_EN
      negativo  <= 1'b0;
      signo     <= 1'b0;
`endif
    end else begin
      estado    <= estado_sig;
      trabajo   <= trabajo_sig;
      contador  <= contador_sig;
      resultado <= resultado_sig;
      terminado <= terminado_sig;
`ifdef CONVERTIDOR_SIGNO_EN
      negativo  <= negativo_sig;
      signo     <= signo_sig;
`endif
    end
  end

  assign bus.resultado_bcd = resultado;
  assign bus.terminado     = terminado;
`ifdef CONVERTIDOR_SIGNO_EN
  assign bus.signo         = signo;
`endif

endmodule

// File: tb/tb_convertidor_binario_bcd.sv
// Directed self-checking bench for convertidor_binario_bcd: latency, hold behaviour, reset abort, boundaries.
// Sign-mode vectors are compiled in when CONVERTIDOR_SIGNO_EN is defined.
module tb_convertidor_binario_bcd;

  logic reloj;
  logic reset;
  int unsigned vectores;
  int unsigned errores;
  logic [19:0] ultimo;

  convertidor_binario_bcd_if #(.ANCHO_BIN(16), .DIGITOS(5)) bus ();

  convertidor_binario_bcd #(.ANCHO_BIN(16), .DIGITOS(5)) dut (
    .reloj (reloj),
    .reset (reset),
    .bus   (bus)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    vectores++;
    if (obs !== esp) begin
      errores++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, esp);
    end
  endtask

  // One full conversion: accept, swap the operand afterwards, check hold at edge 32 and result at edge 33.
  task automatic convertir(input logic [15:0] val, input logic [15:0] cambio,
                           input logic [19:0] esp, input logic esp_signo, input string tag);
    bus.inicio = 1'b0;
    repeat (2) @(negedge reloj);
    bus.entrada_bin = val;
    bus.inicio      = 1'b1;
    @(posedge reloj);
    #1;
    verificar({tag, "_clr"}, 32'(bus.terminado), 32'd0);
    bus.inicio      = 1'b0;
    bus.entrada_bin = cambio;
    repeat (31) @(posedge reloj);
    #1;
    verificar({tag, "_busy32"}, 32'(bus.terminado), 32'd0);
    verificar({tag, "_hold32"}, 32'(bus.resultado_bcd), 32'(ultimo));
    @(posedge reloj);
    #1;
    verificar({tag, "_done33"}, 32'(bus.terminado), 32'd1);
    verificar({tag, "_bcd"}, 32'(bus.resultado_bcd), 32'(esp));
`ifdef CONVERTIDOR_SIGNO_EN
    verificar({tag, "_signo"}, 32'(bus.signo), 32'(esp_signo));
`else
    if (esp_signo) verificar({tag, "_nosigno"}, 32'd0, 32'd1);
`endif
    ultimo = esp;
  endtask

  initial begin
    int unsigned caidas;
    vectores        = 0;
    errores         = 0;
    ultimo          = '0;
    reset           = 1'b0;
    bus.inicio      = 1'b0;
    bus.entrada_bin = '0;

    #12;
    verificar("rst_term", 32'(bus.terminado), 32'd0);
    verificar("rst_bcd", 32'(bus.resultado_bcd), 32'd0);
`ifdef CONVERTIDOR_SIGNO_EN
    verificar("rst_signo", 32'(bus.signo), 32'd0);
`endif
    @(negedge reloj);
    reset = 1'b1;

    convertir(16'd0,     16'd0,     20'h00000, 1'b0, "cero");
    convertir(16'd12345, 16'd12345, 20'h12345, 1'b0, "v12345");
    convertir(16'd9,     16'd9,     20'h00009, 1'b0, "v9");
    convertir(16'd10,    16'd10,    20'h00010, 1'b0, "v10");
    convertir(16'd9999,  16'd9999,  20'h09999, 1'b0, "v9999");
    convertir(16'h7FFF,  16'h7FFF,  20'h32767, 1'b0, "v32767");
`ifndef CONVERTIDOR_SIGNO_EN
    convertir(16'd65535, 16'd65535, 20'h65535, 1'b0, "v65535");
    convertir(16'h8000,  16'h8000,  20'h32768, 1'b0, "v32768");
`endif
    convertir(16'd42,    16'd999,   20'h00042, 1'b0, "captura");

    // inicio held high: one conversion only, terminado must never drop afterwards.
    bus.inicio = 1'b0;
    repeat (2) @(negedge reloj);
    bus.entrada_bin = 16'd500;
    bus.inicio      = 1'b1;
    repeat (33) @(posedge reloj);
    #1;
    verificar("alto_done", 32'(bus.terminado), 32'd1);
    verificar("alto_bcd", 32'(bus.resultado_bcd), 32'h00500);
    caidas = 0;
    for (int k = 0; k < 67; k++) begin
      @(posedge reloj);
      #1;
      if (bus.terminado !== 1'b1 || bus.resultado_bcd !== 20'h00500) caidas++;
    end
    verificar("alto_unico", 32'(caidas), 32'd0);
    ultimo = 20'h00500;
    convertir(16'd7, 16'd7, 20'h00007, 1'b0, "tras_alto");

    // Reset at edge 10 of a conversion aborts it and clears outputs immediately.
    bus.inicio = 1'b0;
    repeat (2) @(negedge reloj);
    bus.entrada_bin = 16'd4321;
    bus.inicio      = 1'b1;
    @(posedge reloj);
    #1;
    bus.inicio = 1'b0;
    repeat (10) @(posedge reloj);
    #2;
    reset = 1'b0;
    #1;
    verificar("abort_term", 32'(bus.terminado), 32'd0);
    verificar("abort_bcd", 32'(bus.resultado_bcd), 32'd0);
    @(negedge reloj);
    reset  = 1'b1;
    ultimo = '0;
    repeat (40) @(posedge reloj);
    #1;
    verificar("abort_idle_term", 32'(bus.terminado), 32'd0);
    verificar("abort_idle_bcd", 32'(bus.resultado_bcd), 32'd0);
    convertir(16'd12345, 16'd12345, 20'h12345, 1'b0, "reinicio");

`ifdef CONVERTIDOR_SIGNO_EN
    convertir(16'hFFFF, 16'hFFFF, 20'h00001, 1'b1, "neg1");
    convertir(16'h8000, 16'h8000, 20'h32768, 1'b1, "negmin");
    convertir(16'h7FFF, 16'h7FFF, 20'h32767, 1'b0, "posmax");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectores, errores);
    $finish;
  end

endmodule
